// File: rtl/udsp_host_loader.sv
`default_nettype none
// ============================================================================
// Module   : udsp_host_loader
// Brief    : Host byte-stream loader for the uDSP core. Parses write/start
//            packets, writes 36-bit words into instruction or data memory,
//            holds the core halted while loading and issues the start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module udsp_host_loader #(
  parameter int IAW = 9,
  parameter int DAW = 10,
  parameter int WW  = 36
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [IAW-1:0] imem_addr,
  output logic [WW-1:0]  imem_data,
  output logic           imem_we,
  output logic [DAW-1:0] dmem_addr,
  output logic [WW-1:0]  dmem_data,
  output logic           dmem_we,
  output logic           dsp_hold,
  output logic           dsp_start,
  output logic           busy,
  output logic           err
);

  // Working address is wide enough for either memory; each port takes its low bits.
  localparam int AMW = (IAW > DAW) ? IAW : DAW;

  localparam logic [7:0] C_CMD_IMEM  = 8'hA5;
  localparam logic [7:0] C_CMD_DMEM  = 8'h5A;
  localparam logic [7:0] C_CMD_START = 8'hC3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_COUNT   = 3'd3,
    S_DATA    = 3'd4,
    S_WRITE   = 3'd5,
    S_START   = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_ready;
  logic             w_accept;
  logic             r_is_dmem;
  logic [AMW-1:0]   r_addr;
  logic [7:0]       r_cnt;
  logic [2:0]       r_idx;
  logic [27:0]      r_word;
  logic [IAW-1:0]   r_imem_addr;
  logic [DAW-1:0]   r_dmem_addr;
  logic [WW-1:0]    r_imem_data;
  logic [WW-1:0]    r_dmem_data;
  logic             r_hold;
  logic             r_err;

  // Bytes are only refused during the single-cycle WRITE and START states.
  assign w_ready  = (r_state != S_WRITE) && (r_state != S_START);
  assign w_accept = in_valid && w_ready;

  assign in_ready  = w_ready;
  assign imem_addr = r_imem_addr;
  assign imem_data = r_imem_data;
  assign dmem_addr = r_dmem_addr;
  assign dmem_data = r_dmem_data;
  assign dsp_hold  = r_hold;
  assign err       = r_err;

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode and state-derived strobes.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    dsp_start    = 1'b0;
    imem_we      = 1'b0;
    dmem_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          if (in_data == C_CMD_IMEM || in_data == C_CMD_DMEM) w_state_next = S_ADDR_HI;
          else if (in_data == C_CMD_START)                     w_state_next = S_START;
        end
      end
      S_ADDR_HI: if (w_accept) w_state_next = S_ADDR_LO;
      S_ADDR_LO: if (w_accept) w_state_next = S_COUNT;
      S_COUNT:   if (w_accept) w_state_next = S_DATA;
      S_DATA:    if (w_accept && r_idx == 3'd4) w_state_next = S_WRITE;
      S_WRITE: begin
        imem_we      = !r_is_dmem;
        dmem_we      = r_is_dmem;
        w_state_next = (r_cnt == 8'd0) ? S_IDLE : S_DATA;
      end
      S_START: begin
        dsp_start    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Packet datapath: header capture, word assembly, memory-port registers, hold/err flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_is_dmem   <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_word      <= '0;
      r_imem_addr <= '0;
      r_imem_data <= '0;
      r_dmem_addr <= '0;
      r_dmem_data <= '0;
      r_hold      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (in_data == C_CMD_IMEM || in_data == C_CMD_DMEM) begin
            r_is_dmem <= (in_data == C_CMD_DMEM);
            r_hold    <= 1'b1;
          end else if (in_data != C_CMD_START) begin
            r_err <= 1'b1;
          end
        end
        S_ADDR_HI: if (w_accept) r_addr <= AMW'({in_data, 8'h00});
        S_ADDR_LO: if (w_accept) r_addr <= r_addr | AMW'(in_data);
        S_COUNT: if (w_accept) begin
          r_cnt <= in_data;
          r_idx <= 3'd0;
        end
        S_DATA: if (w_accept) begin
          if (r_idx == 3'd0) begin
            // Only the low nibble of the first byte carries word bits [35:32].
            r_word <= {24'd0, in_data[3:0]};
            r_idx  <= 3'd1;
          end else if (r_idx != 3'd4) begin
            r_word <= {r_word[19:0], in_data};
            r_idx  <= r_idx + 3'd1;
          end else begin
            r_idx <= 3'd0;
            if (r_is_dmem) begin
              r_dmem_addr <= r_addr[DAW-1:0];
              r_dmem_data <= {r_word, in_data};
            end else begin
              r_imem_addr <= r_addr[IAW-1:0];
              r_imem_data <= {r_word, in_data};
            end
            r_addr <= r_addr + AMW'(1);
          end
        end
        S_WRITE: if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        S_START: r_hold <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udsp_host_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_udsp_host_loader
// Brief    : Self-checking bench for udsp_host_loader; packets are generated
//            with random payloads and the expected memory writes are derived
//            from the packet contents with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udsp_host_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  imem_addr;
  logic [35:0] imem_data;
  logic        imem_we;
  logic [9:0]  dmem_addr;
  logic [35:0] dmem_data;
  logic        dmem_we;
  logic        dsp_hold;
  logic        dsp_start;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int start_pulses = 0;

  // Write records: {is_dmem, addr[9:0], data[35:0]}
  logic [46:0] exp_q[$];
  logic [46:0] act_q[$];

  always #5 clk = ~clk;

  udsp_host_loader #(.IAW(9), .DAW(10), .WW(36)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_addr(imem_addr), .imem_data(imem_data), .imem_we(imem_we),
    .dmem_addr(dmem_addr), .dmem_data(dmem_data), .dmem_we(dmem_we),
    .dsp_hold(dsp_hold), .dsp_start(dsp_start), .busy(busy), .err(err)
  );

  // Record every write strobe and start pulse seen mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (imem_we)   act_q.push_back({1'b0, 1'b0, imem_addr, imem_data});
      if (dmem_we)   act_q.push_back({1'b1, dmem_addr, dmem_data});
      if (dsp_start) start_pulses++;
    end
  end

  // Offer one byte from a falling edge, wait (bounded) for acceptance, then optional idle gap.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    int stall;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL send_byte timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    stall = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (stall) @(negedge clk);
  endtask

  // Send a full write packet with random words and queue the writes it must produce.
  task automatic send_wr(input logic [7:0] cmd, input logic [15:0] a,
                         input logic [7:0] cnt, input int gap);
    logic [35:0] wd;
    logic [7:0]  b0;
    int          aw;
    send_byte(cmd, gap);
    send_byte(a[15:8], gap);
    send_byte(a[7:0], gap);
    send_byte(cnt, gap);
    for (int w = 0; w <= int'(cnt); w++) begin
      wd = {4'($urandom), 32'($urandom)};
      b0 = {4'($urandom), wd[35:32]};
      send_byte(b0, gap);
      send_byte(wd[31:24], gap);
      send_byte(wd[23:16], gap);
      send_byte(wd[15:8], gap);
      send_byte(wd[7:0], gap);
      aw = (cmd == 8'h5A) ? ((int'(a) + w) % 1024) : ((int'(a) + w) % 512);
      exp_q.push_back({(cmd == 8'h5A), 10'(aw), wd});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_tests++; if ({imem_we, dmem_we, dsp_start, dsp_hold, busy, err} !== 6'b0) begin
      n_fail++; $display("FAIL reset flags: got %b want 000000", {imem_we, dmem_we, dsp_start, dsp_hold, busy, err}); end
    n_tests++; if ({imem_addr, imem_data, dmem_addr, dmem_data} !== '0) begin
      n_fail++; $display("FAIL reset addr/data: got %h %h %h %h want 0", imem_addr, imem_data, dmem_addr, dmem_data); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start(input logic [8*12-1:0] name);
    start_pulses = 0;
    send_byte(8'hC3, 0);
    n_tests++; if ({dsp_start, in_ready, busy} !== 3'b101) begin
      n_fail++; $display("FAIL %0s start cycle: got start/ready/busy=%b want 101", name, {dsp_start, in_ready, busy}); end
    @(negedge clk);
    n_tests++; if ({dsp_start, dsp_hold, busy, in_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL %0s after start: got start/hold/busy/ready=%b want 0001", name, {dsp_start, dsp_hold, busy, in_ready}); end
    repeat (2) @(negedge clk);
    n_tests++; if (start_pulses != 1) begin n_fail++; $display("FAIL %0s pulse count: got %0d want 1", name, start_pulses); end
    n_tests++; if (act_q.size() != 0) begin n_fail++; $display("FAIL %0s stray writes: got %0d want 0", name, act_q.size()); end
    act_q.delete();
  endtask

  task automatic test_imem_single();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    send_byte(8'h05, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    exp_q.push_back({1'b0, 10'h010, 36'h5_1234_5678});
    n_tests++; if ({imem_we, dmem_we, in_ready} !== 3'b100) begin
      n_fail++; $display("FAIL imem latency: got we_i/we_d/ready=%b want 100", {imem_we, dmem_we, in_ready}); end
    @(negedge clk);
    n_tests++; if ({imem_we, in_ready, dsp_hold, busy} !== 4'b0110) begin
      n_fail++; $display("FAIL imem after write: got we/ready/hold/busy=%b want 0110", {imem_we, in_ready, dsp_hold, busy}); end
    n_tests++; if ({imem_addr, imem_data} !== {9'h010, 36'h5_1234_5678}) begin
      n_fail++; $display("FAIL imem hold value: got %h %h want 010 512345678", imem_addr, imem_data); end
    repeat (2) @(negedge clk);
    n_tests++;
    if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL imem_single count: got %0d want %0d", act_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin n_tests++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL imem_single write %0d: got %h want %h", i, act_q[i], exp_q[i]); end end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_packet(input logic [8*12-1:0] name, input logic [7:0] cmd,
                             input logic [15:0] a, input logic [7:0] cnt, input int gap);
    send_wr(cmd, a, cnt, gap);
    repeat (3) @(negedge clk);
    n_tests++; if ({dsp_hold, busy} !== 2'b10) begin n_fail++; $display("FAIL %0s hold/busy: got %b want 10", name, {dsp_hold, busy}); end
    n_tests++;
    if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL %0s count: got %0d want %0d", name, act_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin n_tests++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL %0s write %0d: got %h want %h", name, i, act_q[i], exp_q[i]); end end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_err();
    send_byte(8'h77, 0);
    @(negedge clk);
    n_tests++; if ({err, busy, imem_we, dmem_we} !== 4'b1000) begin
      n_fail++; $display("FAIL err flag: got err/busy/we_i/we_d=%b want 1000", {err, busy, imem_we, dmem_we}); end
    test_packet("after_err", 8'hA5, 16'h0123, 8'd1, 0);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err sticky: got %b want 1", err); end
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    for (int k = 0; k < 8; k++) begin
      cmd = ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'h5A;
      test_packet("random", cmd, 16'($urandom), 8'($urandom_range(0, 4)), 2);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h23, 0); send_byte(8'h01, 0);
    send_byte(8'h0F, 0); send_byte(8'hAA, 0); send_byte(8'h55, 0);
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if ({imem_we, dmem_we, dsp_hold, err, busy, in_ready} !== 6'b000001) begin
      n_fail++; $display("FAIL reset_mid flags: got %b want 000001", {imem_we, dmem_we, dsp_hold, err, busy, in_ready}); end
    n_tests++; if ({imem_addr, imem_data, dmem_addr, dmem_data} !== '0) begin
      n_fail++; $display("FAIL reset_mid addr/data: got %h %h %h %h want 0", imem_addr, imem_data, dmem_addr, dmem_data); end
    reset = 1'b1;
    @(negedge clk);
    test_packet("after_rst", 8'h5A, 16'h0040, 8'd0, 0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_start("start_nohold");
    test_imem_single();
    test_packet("dmem_wrap", 8'h5A, 16'h03FE, 8'd2, 0);
    test_start("start_load");
    test_err();
    test_packet("stall", 8'hA5, 16'h0155, 8'd1, 1);
    test_random();
    test_packet("imem_full", 8'hA5, 16'hFFF0, 8'd255, 0);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
